// File: rtl/prog_clk_div.sv
// Programmable integer clock divider: registered clk/N output plus a one-cycle tick per period.
// The ratio is loaded by valid/ready and only takes effect on a period boundary.
module prog_clk_div #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             div_clk_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] cur_div,
    output logic             active_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W:0]   ONE_X   = (CNT_W+1)'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_vld;
    logic             r_div_clk;
    logic             r_tick;

    logic [1:0]       w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_cur_div_d;
    logic [CNT_W-1:0] w_pend_div_d;
    logic             w_pend_vld_d;
    logic             w_div_clk_d;
    logic             w_tick_d;

    logic             w_xfer;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cfg_clamped;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W:0]   w_half;

    assign cfg_ready     = (r_state == IDLE) || !r_pend_vld;
    assign w_xfer        = cfg_valid && cfg_ready;
    assign w_cfg_clamped = (cfg_div < TWO) ? TWO : cfg_div;
    assign w_wrap        = (r_cnt == (r_cur_div - ONE));
    assign w_cnt_inc     = r_cnt + ONE;
    // One extra bit so the maximum ratio does not overflow when rounding up.
    assign w_half        = ({1'b0, r_cur_div} + ONE_X) >> 1;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_cur_div_d  = r_cur_div;
        w_pend_div_d = r_pend_div;
        w_pend_vld_d = r_pend_vld;
        w_div_clk_d  = 1'b0;
        w_tick_d     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                if (w_xfer) w_cur_div_d = w_cfg_clamped;
                if (en) begin
                    w_state_d   = RUN;
                    w_div_clk_d = 1'b1;
                    w_tick_d    = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (w_wrap) begin
                    // Period boundary: a pending ratio wins, else a same-edge transfer applies.
                    w_cnt_d = '0;
                    if (r_pend_vld) begin
                        w_cur_div_d  = r_pend_div;
                        w_pend_vld_d = 1'b0;
                    end else if (w_xfer) begin
                        w_cur_div_d = w_cfg_clamped;
                    end
                    if (en) begin
                        w_state_d   = RUN;
                        w_div_clk_d = 1'b1;
                        w_tick_d    = 1'b1;
                    end else begin
                        w_state_d = IDLE;
                    end
                end else begin
                    w_cnt_d = w_cnt_inc;
                    if (w_xfer) begin
                        w_pend_div_d = w_cfg_clamped;
                        w_pend_vld_d = 1'b1;
                    end
                    w_state_d   = en ? RUN : DRAIN;
                    w_div_clk_d = ({1'b0, w_cnt_inc} < w_half);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cur_div  <= DEF_DIV;
            r_pend_div <= '0;
            r_pend_vld <= 1'b0;
            r_div_clk  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_cur_div  <= w_cur_div_d;
            r_pend_div <= w_pend_div_d;
            r_pend_vld <= w_pend_vld_d;
            r_div_clk  <= w_div_clk_d;
            r_tick     <= w_tick_d;
        end
    end

    assign div_clk_o = r_div_clk;
    assign tick_o    = r_tick;
    assign cur_div   = r_cur_div;
    assign active_o  = (r_state != IDLE);

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: ratio table swept over whole periods, plus hand-written sequences
// for mid-run reload, drain/resume and reset during a pending reload.
module tb_prog_clk_div;

    typedef struct {
        logic       div;
        logic       tick;
        logic [7:0] cur;
        logic       act;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic [7:0] cfg;
        logic [7:0] cur;
        int         hi;
        int         lo;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       div_clk_o;
    logic       tick_o;
    logic [7:0] cur_div;
    logic       active_o;

    exp_t sb[$];
    vec_t vecs[7];
    int   total;
    int   bad;

    prog_clk_div #(
        .CNT_W      (8),
        .DEFAULT_DIV(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .div_clk_o(div_clk_o),
        .tick_o   (tick_o),
        .cur_div  (cur_div),
        .active_o (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expectation is queued for the coming edge and popped once that edge has settled.
    task automatic step(input string nm, input logic d, input logic t, input logic [7:0] c,
                        input logic a, input logic r);
        exp_t e;
        sb.push_back('{d, t, c, a, r});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if ({div_clk_o, tick_o, cur_div, active_o, cfg_ready} !==
            {e.div, e.tick, e.cur, e.act, e.rdy}) begin
            bad++;
            $display("FAIL %s: got div=%0b tick=%0b cur=%0d act=%0b rdy=%0b want div=%0b tick=%0b cur=%0d act=%0b rdy=%0b",
                     nm, div_clk_o, tick_o, cur_div, active_o, cfg_ready,
                     e.div, e.tick, e.cur, e.act, e.rdy);
        end
    endtask

    task automatic do_reset(input string nm);
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        step(nm, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic load_idle(input string nm, input logic [7:0] v, input logic [7:0] c);
        cfg_valid = 1'b1;
        cfg_div   = v;
        step(nm, 1'b0, 1'b0, c, 1'b0, 1'b1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        vecs[0] = '{8'd2,   8'd2,   1,   1};
        vecs[1] = '{8'd5,   8'd5,   3,   2};
        vecs[2] = '{8'd6,   8'd6,   3,   3};
        vecs[3] = '{8'd3,   8'd3,   2,   1};
        vecs[4] = '{8'd0,   8'd2,   1,   1};
        vecs[5] = '{8'd1,   8'd2,   1,   1};
        vecs[6] = '{8'd255, 8'd255, 128, 127};

        // Reset default and default ratio
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
        rst_n = 1'b1;
        step("idle", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step("def_hi", 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);
            step("def_lo", 1'b0, 1'b0, 8'd2, 1'b1, 1'b1);
        end

        // Ratio table, including clamp and maximum ratio
        for (int v = 0; v < 7; v++) begin
            do_reset("tbl_rst");
            load_idle("tbl_load", vecs[v].cfg, vecs[v].cur);
            en = 1'b1;
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < vecs[v].hi; k++)
                    step("tbl_hi", 1'b1, (k == 0), vecs[v].cur, 1'b1, 1'b1);
                for (int k = 0; k < vecs[v].lo; k++)
                    step("tbl_lo", 1'b0, 1'b0, vecs[v].cur, 1'b1, 1'b1);
            end
            en = 1'b0;
        end

        // Mid-run change 4 -> 6, then same-edge transfer at wrap 6 -> 3
        do_reset("t3_rst");
        load_idle("t3_load", 8'd4, 8'd4);
        en = 1'b1;
        step("t3_c0", 1'b1, 1'b1, 8'd4, 1'b1, 1'b1);
        step("t3_c1", 1'b1, 1'b0, 8'd4, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        step("t3_c2", 1'b0, 1'b0, 8'd4, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        cfg_div   = 8'd9;
        step("t3_c3", 1'b0, 1'b0, 8'd4, 1'b1, 1'b0);
        step("t3_n0", 1'b1, 1'b1, 8'd6, 1'b1, 1'b1);
        step("t3_n1", 1'b1, 1'b0, 8'd6, 1'b1, 1'b1);
        step("t3_n2", 1'b1, 1'b0, 8'd6, 1'b1, 1'b1);
        step("t3_n3", 1'b0, 1'b0, 8'd6, 1'b1, 1'b1);
        step("t3_n4", 1'b0, 1'b0, 8'd6, 1'b1, 1'b1);
        step("t3_n5", 1'b0, 1'b0, 8'd6, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        step("t3_w0", 1'b1, 1'b1, 8'd3, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        step("t3_w1", 1'b1, 1'b0, 8'd3, 1'b1, 1'b1);
        step("t3_w2", 1'b0, 1'b0, 8'd3, 1'b1, 1'b1);
        step("t3_w3", 1'b1, 1'b1, 8'd3, 1'b1, 1'b1);

        // Graceful stop with a pending ratio, then drain-and-resume
        do_reset("t5_rst");
        load_idle("t5_load", 8'd8, 8'd8);
        en = 1'b1;
        step("t5_c0", 1'b1, 1'b1, 8'd8, 1'b1, 1'b1);
        step("t5_c1", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);
        step("t5_c2", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);
        en = 1'b0;
        step("t5_d3", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);
        step("t5_d4", 1'b0, 1'b0, 8'd8, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        step("t5_d5", 1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        step("t5_d6", 1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
        step("t5_d7", 1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
        step("t5_idle", 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
        step("t5_idle2", 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
        load_idle("t5_reload", 8'd8, 8'd8);
        en = 1'b1;
        step("t5_r0", 1'b1, 1'b1, 8'd8, 1'b1, 1'b1);
        step("t5_r1", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);
        step("t5_r2", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);
        en = 1'b0;
        step("t5_r3", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);
        en = 1'b1;
        step("t5_r4", 1'b0, 1'b0, 8'd8, 1'b1, 1'b1);
        for (int k = 5; k < 8; k++) step("t5_rlo", 1'b0, 1'b0, 8'd8, 1'b1, 1'b1);
        step("t5_rw0", 1'b1, 1'b1, 8'd8, 1'b1, 1'b1);
        step("t5_rw1", 1'b1, 1'b0, 8'd8, 1'b1, 1'b1);

        // Reset while a reload is pending discards it
        do_reset("t6_rst0");
        load_idle("t6_load", 8'd6, 8'd6);
        en = 1'b1;
        step("t6_c0", 1'b1, 1'b1, 8'd6, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        step("t6_c1", 1'b1, 1'b0, 8'd6, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        step("t6_rst", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
        rst_n = 1'b1;
        step("t6_a0", 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);
        step("t6_a1", 1'b0, 1'b0, 8'd2, 1'b1, 1'b1);
        step("t6_a2", 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
